tmma_issue_ctrl: RTL and testbench
==================================

Name: tmma_issue_ctrl

Overview:
Sequencer that runs one TMMA operation on the ROWS x COLS PE systolic array. It accepts a command carrying the reduction length K and the precision, then pulls K A-column vectors and K B-row vectors from the operand buffers. It applies the diagonal skew and drives the array's left and top edges, then waits for the array to drain and pulses done. The PE array inserts one register stage per PE hop, so edge lane i must lead lane i+1 by one cycle.

Parameters:
ROWS, 4, PE array rows (left-edge lanes)
COLS, 4, PE array columns (top-edge lanes)
MAC_LAT, 2, mac pipeline latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_k_i  in  TMMA_CNT_WIDTH  reduction length K
cmd_precision_i  in  TMMA_PRECISION_WIDTH  operand precision
a_valid_i  in  1  A column vector valid
a_ready_o  out  1  A vector consumed
a_data_i  in  ROWS*PE_INPUT_DATA_WIDTH  A column, lane i = row i
b_valid_i  in  1  B row vector valid
b_ready_o  out  1  B vector consumed
b_data_i  in  COLS*PE_INPUT_DATA_WIDTH  B row, lane j = column j
left_data_valid_o  out  ROWS  per-row left-edge valid
left_data_cnt_o  out  ROWS*TMMA_CNT_WIDTH  step index k per row
left_data_type_o  out  ROWS  PE_DATA_TYPE_A whenever valid, else 0
left_precision_o  out  ROWS*TMMA_PRECISION_WIDTH  latched precision
left_data_o  out  ROWS*PE_INPUT_DATA_WIDTH  skewed A elements
top_data_valid_o  out  COLS  per-column top-edge valid
top_data_cnt_o  out  COLS*TMMA_CNT_WIDTH  step index k per column
top_data_o  out  COLS*PE_INPUT_DATA_WIDTH  skewed B elements
top_storec_valid_o  out  COLS  tied 0 (C preload unsupported in this block)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; step/drain counters, latched K and precision, and all skew registers cleared. All outputs are 0, except cmd_ready_o=1 once IDLE.
- FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch K and precision and clear step counter k.
  - K!=0 goes to FEED. K==0 goes directly to DONE: no operand pulls, no edge valids.
- FEED:
  - a_ready_o = FEED & b_valid_i; b_ready_o = FEED & a_valid_i.
  - fire = FEED & a_valid_i & b_valid_i. A and B are always consumed together.
  - On fire, stage 0 of every lane loads {valid=1, cnt=k, data}; k increments.
  - A cycle without fire loads a bubble (valid=0, data=0, cnt=0) into stage 0.
  - The fire with k==K-1 moves to DRAIN.
- Skew:
  - Row lane i has an i+1-deep register chain; column lane j has a j+1-deep chain.
  - A fire at cycle t appears on left lane i at t+1+i and on top lane j at t+1+j.
  - Chains shift every cycle in all states, so bubbles propagate exactly as stalls occurred.
  - left_precision_o is the latched precision on all lanes.
- DRAIN:
  - D = ROWS+COLS-2+MAC_LAT. The drain counter counts D cycles (t+1..t+D after the last fire at t), then goes to DONE.
  - a_ready_o = b_ready_o = 0.
- DONE: done_o=1 for exactly one cycle, next state IDLE. cmd_ready_o rises the following cycle.
- cmd_ready_o is 0 in FEED, DRAIN and DONE; commands presented then are held off, not dropped.
- Counter widths:
  - k and K are TMMA_CNT_WIDTH wide; maximum K = 2^TMMA_CNT_WIDTH-1.
  - Comparison is k==K-1 computed at full width, so no wrap occurs.
  - The drain counter is $clog2(D+1) bits.
- Reset mid-operation: immediate return to IDLE. Skew chains are cleared, so no partial valids reach the array after reset release. The interrupted command is lost; done_o is not pulsed.
- Operand data arriving with valid while in IDLE or DRAIN is not consumed.

Decomposition:
- Shared defines header (existing): TMMA_CNT_WIDTH, TMMA_PRECISION_WIDTH, PE_INPUT_DATA_WIDTH, PE_DATA_TYPE_A.
- Add TMMA_ISSUE_ST_IDLE/FEED/DRAIN/DONE state encodings (2 bits) to the same header.
- One sub-module: tmma_skew_lane, parameterised by DEPTH. It is a chain of {valid, cnt, data} registers with async clear, instantiated ROWS+COLS times via generate.

Test Plan:
- ROWS=COLS=4, MAC_LAT=2, K=3, operands always valid, fires at cycles 1,2,3:
  - left valid row0 at 2..4 and row3 at 5..7, with cnt 0,1,2.
  - DRAIN cycles 4..11; done_o at cycle 12; cmd_ready_o=1 at 13.
- K=3 with b_valid_i low for 2 cycles after the first fire:
  - a_ready_o low during the gap.
  - A 2-cycle bubble appears on every lane, shifted by the lane index.
  - cnt sequence is still 0,1,2; done is delayed by 2 cycles.
- K=0: cmd accepted, done_o the next cycle, a_ready_o/b_ready_o never 1, all edge valids stay 0.
- rst_n asserted after the 2nd fire of a K=5 command: all outputs 0 immediately.
  - After release: IDLE, cmd_ready_o=1, no residual edge valids, no done_o.
- Back-to-back commands with cmd_valid_i held high:
  - The second command is accepted only on the cycle after done_o.
  - Precision switches from value 1 to 2 on left_precision_o from that point onward.

Source files
------------

// File: rtl/tmma_issue_ctrl_pkg.sv
// Shared widths, encodings and lane beat type for the TMMA issue controller.
// The FSM state encodings are fixed 2-bit values so other blocks can decode them.
package tmma_issue_ctrl_pkg;

  localparam int TMMA_CNT_WIDTH       = 8;
  localparam int TMMA_PRECISION_WIDTH = 2;
  localparam int PE_INPUT_DATA_WIDTH  = 8;
  localparam logic PE_DATA_TYPE_A     = 1'b1;

  localparam logic [1:0] TMMA_ISSUE_ST_IDLE  = 2'd0;
  localparam logic [1:0] TMMA_ISSUE_ST_FEED  = 2'd1;
  localparam logic [1:0] TMMA_ISSUE_ST_DRAIN = 2'd2;
  localparam logic [1:0] TMMA_ISSUE_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = TMMA_ISSUE_ST_IDLE,
    ST_FEED  = TMMA_ISSUE_ST_FEED,
    ST_DRAIN = TMMA_ISSUE_ST_DRAIN,
    ST_DONE  = TMMA_ISSUE_ST_DONE
  } issue_state_e;

  // One element travelling along an array edge lane.
  typedef struct packed {
    logic                           valid;
    logic [TMMA_CNT_WIDTH-1:0]      cnt;
    logic [PE_INPUT_DATA_WIDTH-1:0] data;
  } lane_beat_t;

  // Cycles from the last edge element entering the array until its result settles.
  function automatic int drain_cycles(input int rows, input int cols, input int mac_lat);
    return rows + cols - 2 + mac_lat;
  endfunction

endpackage

// File: rtl/tmma_issue_ctrl_if.sv
// Command, operand-buffer and array-edge bundle of the TMMA issue controller.
// slave = controller side, master = the surrounding command/operand/array logic.
interface tmma_issue_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import tmma_issue_ctrl_pkg::*;

  logic                                 cmd_valid_i;
  logic                                 cmd_ready_o;
  logic [TMMA_CNT_WIDTH-1:0]            cmd_k_i;
  logic [TMMA_PRECISION_WIDTH-1:0]      cmd_precision_i;
  logic                                 a_valid_i;
  logic                                 a_ready_o;
  logic [ROWS*PE_INPUT_DATA_WIDTH-1:0]  a_data_i;
  logic                                 b_valid_i;
  logic                                 b_ready_o;
  logic [COLS*PE_INPUT_DATA_WIDTH-1:0]  b_data_i;
  logic [ROWS-1:0]                      left_data_valid_o;
  logic [ROWS*TMMA_CNT_WIDTH-1:0]       left_data_cnt_o;
  logic [ROWS-1:0]                      left_data_type_o;
  logic [ROWS*TMMA_PRECISION_WIDTH-1:0] left_precision_o;
  logic [ROWS*PE_INPUT_DATA_WIDTH-1:0]  left_data_o;
  logic [COLS-1:0]                      top_data_valid_o;
  logic [COLS*TMMA_CNT_WIDTH-1:0]       top_data_cnt_o;
  logic [COLS*PE_INPUT_DATA_WIDTH-1:0]  top_data_o;
  logic [COLS-1:0]                      top_storec_valid_o;
  logic                                 busy_o;
  logic                                 done_o;

  modport slave (
    input  cmd_valid_i, cmd_k_i, cmd_precision_i,
    input  a_valid_i, a_data_i, b_valid_i, b_data_i,
    output cmd_ready_o, a_ready_o, b_ready_o,
    output left_data_valid_o, left_data_cnt_o, left_data_type_o, left_precision_o, left_data_o,
    output top_data_valid_o, top_data_cnt_o, top_data_o, top_storec_valid_o,
    output busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_k_i, cmd_precision_i,
    output a_valid_i, a_data_i, b_valid_i, b_data_i,
    input  cmd_ready_o, a_ready_o, b_ready_o,
    input  left_data_valid_o, left_data_cnt_o, left_data_type_o, left_precision_o, left_data_o,
    input  top_data_valid_o, top_data_cnt_o, top_data_o, top_storec_valid_o,
    input  busy_o, done_o
  );

endinterface

// File: rtl/tmma_skew_lane.sv
// DEPTH-stage delay chain for one array edge lane; shifts every cycle so that
// stalls reach the array as bubbles in exactly the order they occurred.
module tmma_skew_lane
  import tmma_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  lane_beat_t i_beat,
  output lane_beat_t o_beat
);

  lane_beat_t r_chain [DEPTH];

  // NOTE: every stage is reset, not just valid, so a reset mid-operation can
  // never release stale cnt/data or a partial valid into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) r_chain[s] <= '0;
    end else begin
      r_chain[0] <= i_beat;
      for (int s = 1; s < DEPTH; s++) r_chain[s] <= r_chain[s-1];
    end
  end

  assign o_beat = r_chain[DEPTH-1];

endmodule

// File: rtl/tmma_issue_ctrl.sv
// Runs one TMMA operation: pulls K paired A/B vectors, skews them onto the
// array's left/top edges, waits for the array to drain, then pulses done.
module tmma_issue_ctrl
  import tmma_issue_ctrl_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tmma_issue_ctrl_if.slave   bus
);

  localparam int CW  = TMMA_CNT_WIDTH;
  localparam int PW  = TMMA_PRECISION_WIDTH;
  localparam int DW  = PE_INPUT_DATA_WIDTH;
  localparam int D   = drain_cycles(ROWS, COLS, MAC_LAT);
  localparam int DCW = $clog2(D + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(D - 1);

  issue_state_e   r_state;
  logic           r_cmd_ready;
  logic [CW-1:0]  r_k;
  logic [CW-1:0]  r_k_max;
  logic [PW-1:0]  r_precision;
  logic [DCW-1:0] r_drain_cnt;

  logic w_feed;
  logic w_fire;
  logic w_last_fire;

  assign w_feed      = (r_state == ST_FEED);
  assign w_fire      = w_feed & bus.a_valid_i & bus.b_valid_i;
  assign w_last_fire = w_fire & (r_k == r_k_max - CW'(1));

  // cmd_ready is a register so it stays low while reset is held and rises on
  // the first edge after release (and on the edge after DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_k         <= '0;
      r_k_max     <= '0;
      r_precision <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid_i && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_k_max     <= bus.cmd_k_i;
            r_precision <= bus.cmd_precision_i;
            r_k         <= '0;
            r_state     <= (bus.cmd_k_i != '0) ? ST_FEED : ST_DONE;
          end
        end
        ST_FEED: begin
          if (w_fire) begin
            r_k <= r_k + CW'(1);
            if (w_last_fire) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) r_state <= ST_DONE;
          else                           r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o        = r_cmd_ready;
  assign bus.busy_o             = (r_state != ST_IDLE);
  assign bus.done_o             = (r_state == ST_DONE);
  assign bus.a_ready_o          = w_feed & bus.b_valid_i;
  assign bus.b_ready_o          = w_feed & bus.a_valid_i;
  assign bus.top_storec_valid_o = '0;

  lane_beat_t w_row_in  [ROWS];
  lane_beat_t w_row_out [ROWS];
  lane_beat_t w_col_in  [COLS];
  lane_beat_t w_col_out [COLS];

  // NOTE: each lane input is defaulted to a bubble before the fire override so
  // this block stays purely combinational with no inferred latch.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      w_row_in[i] = '0;
      if (w_fire) w_row_in[i] = '{valid: 1'b1, cnt: r_k, data: bus.a_data_i[i*DW +: DW]};
    end
    for (int j = 0; j < COLS; j++) begin
      w_col_in[j] = '0;
      if (w_fire) w_col_in[j] = '{valid: 1'b1, cnt: r_k, data: bus.b_data_i[j*DW +: DW]};
    end
  end

  // Lane n is n+1 stages deep, matching one PE hop per lane index.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    tmma_skew_lane #(.DEPTH(gi + 1)) u_lane (
      .clk(clk), .rst_n(rst_n), .i_beat(w_row_in[gi]), .o_beat(w_row_out[gi])
    );
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    tmma_skew_lane #(.DEPTH(gj + 1)) u_lane (
      .clk(clk), .rst_n(rst_n), .i_beat(w_col_in[gj]), .o_beat(w_col_out[gj])
    );
  end

  logic [ROWS-1:0]    w_left_valid;
  logic [ROWS-1:0]    w_left_type;
  logic [ROWS*CW-1:0] w_left_cnt;
  logic [ROWS*PW-1:0] w_left_prec;
  logic [ROWS*DW-1:0] w_left_data;
  logic [COLS-1:0]    w_top_valid;
  logic [COLS*CW-1:0] w_top_cnt;
  logic [COLS*DW-1:0] w_top_data;

  always_comb begin
    w_left_valid = '0;
    w_left_type  = '0;
    w_left_cnt   = '0;
    w_left_prec  = '0;
    w_left_data  = '0;
    w_top_valid  = '0;
    w_top_cnt    = '0;
    w_top_data   = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_left_valid[i]          = w_row_out[i].valid;
      w_left_type[i]           = w_row_out[i].valid ? PE_DATA_TYPE_A : 1'b0;
      w_left_cnt[i*CW +: CW]   = w_row_out[i].cnt;
      w_left_prec[i*PW +: PW]  = r_precision;
      w_left_data[i*DW +: DW]  = w_row_out[i].data;
    end
    for (int j = 0; j < COLS; j++) begin
      w_top_valid[j]           = w_col_out[j].valid;
      w_top_cnt[j*CW +: CW]    = w_col_out[j].cnt;
      w_top_data[j*DW +: DW]   = w_col_out[j].data;
    end
  end

  assign bus.left_data_valid_o = w_left_valid;
  assign bus.left_data_type_o  = w_left_type;
  assign bus.left_data_cnt_o   = w_left_cnt;
  assign bus.left_precision_o  = w_left_prec;
  assign bus.left_data_o       = w_left_data;
  assign bus.top_data_valid_o  = w_top_valid;
  assign bus.top_data_cnt_o    = w_top_cnt;
  assign bus.top_data_o        = w_top_data;

endmodule

// File: tb/tb_tmma_issue_ctrl.sv
// Directed bench for tmma_issue_ctrl: nominal, stalled, K=0, mid-op reset and
// back-to-back commands, with expected edge timing derived from the fire cycles.
module tb_tmma_issue_ctrl;
  import tmma_issue_ctrl_pkg::*;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int MAC_LAT = 2;
  localparam int CW      = 8;
  localparam int PW      = 2;
  localparam int DW      = 8;
  localparam int DRAIN   = 8;   // 4 + 4 - 2 + 2

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmma_issue_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  tmma_issue_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] a_elem(input int n, input int i);
    return {4'(n), 4'(i)};
  endfunction

  function automatic logic [7:0] b_elem(input int n, input int j);
    return {4'(n + 8), 4'(j)};
  endfunction

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, " cmd_ready"},  64'(bus.cmd_ready_o), 64'(exp_ready));
    check({tag, " busy"},       64'(bus.busy_o), 64'd0);
    check({tag, " done"},       64'(bus.done_o), 64'd0);
    check({tag, " a_ready"},    64'(bus.a_ready_o), 64'd0);
    check({tag, " b_ready"},    64'(bus.b_ready_o), 64'd0);
    check({tag, " left_valid"}, 64'(bus.left_data_valid_o), 64'd0);
    check({tag, " left_cnt"},   64'(bus.left_data_cnt_o), 64'd0);
    check({tag, " left_data"},  64'(bus.left_data_o), 64'd0);
    check({tag, " left_type"},  64'(bus.left_data_type_o), 64'd0);
    check({tag, " top_valid"},  64'(bus.top_data_valid_o), 64'd0);
    check({tag, " top_cnt"},    64'(bus.top_data_cnt_o), 64'd0);
    check({tag, " top_data"},   64'(bus.top_data_o), 64'd0);
  endtask

  // One command starting at local cycle 0 (the accept cycle) through its done cycle.
  // gap: cycles b_valid_i is held low right after the first fire.
  task automatic run_op(input int k, input int prec, input int gap, input int prev_prec,
                        input bit hold, input int next_k, input int next_prec);
    int fire_cyc [16];
    int last_fire, done_cyc, fn;
    bit bv;
    logic [63:0] e_lv, e_lt, e_lc, e_ld, e_lp, e_tv, e_tc, e_td;
    string t;
    for (int n = 0; n < k; n++) fire_cyc[n] = 1 + n + ((n >= 1) ? gap : 0);
    last_fire = (k == 0) ? 0 : fire_cyc[k-1];
    done_cyc  = (k == 0) ? 1 : last_fire + DRAIN + 1;
    for (int c = 0; c <= done_cyc; c++) begin
      bv = !(c >= 2 && c < 2 + gap);
      fn = 0;
      for (int n = 0; n < k; n++) if (fire_cyc[n] == c) fn = n;
      bus.cmd_valid_i     = (c == 0) || hold;
      bus.cmd_k_i         = (c == 0) ? 8'(k) : 8'(next_k);
      bus.cmd_precision_i = (c == 0) ? 2'(prec) : 2'(next_prec);
      bus.a_valid_i       = 1'b1;
      bus.b_valid_i       = bv;
      for (int i = 0; i < ROWS; i++) bus.a_data_i[i*DW +: DW] = a_elem(fn, i);
      for (int j = 0; j < COLS; j++) bus.b_data_i[j*DW +: DW] = b_elem(fn, j);
      #1;
      t = $sformatf("k%0d g%0d c%0d", k, gap, c);
      check({t, " cmd_ready"}, 64'(bus.cmd_ready_o), 64'(c == 0));
      check({t, " busy"},      64'(bus.busy_o), 64'(c != 0));
      check({t, " done"},      64'(bus.done_o), 64'(c == done_cyc));
      check({t, " a_ready"},   64'(bus.a_ready_o), 64'(c >= 1 && c <= last_fire && bv));
      check({t, " b_ready"},   64'(bus.b_ready_o), 64'(c >= 1 && c <= last_fire));
      e_lv = '0; e_lt = '0; e_lc = '0; e_ld = '0; e_lp = '0;
      e_tv = '0; e_tc = '0; e_td = '0;
      for (int i = 0; i < ROWS; i++) begin
        e_lp[i*PW +: PW] = (c == 0) ? 2'(prev_prec) : 2'(prec);
        for (int n = 0; n < k; n++) if (fire_cyc[n] + 1 + i == c) begin
          e_lv[i] = 1'b1;
          e_lt[i] = 1'b1;
          e_lc[i*CW +: CW] = 8'(n);
          e_ld[i*DW +: DW] = a_elem(n, i);
        end
      end
      for (int j = 0; j < COLS; j++) begin
        for (int n = 0; n < k; n++) if (fire_cyc[n] + 1 + j == c) begin
          e_tv[j] = 1'b1;
          e_tc[j*CW +: CW] = 8'(n);
          e_td[j*DW +: DW] = b_elem(n, j);
        end
      end
      check({t, " left_valid"}, 64'(bus.left_data_valid_o), e_lv);
      check({t, " left_type"},  64'(bus.left_data_type_o), e_lt);
      check({t, " left_cnt"},   64'(bus.left_data_cnt_o), e_lc);
      check({t, " left_data"},  64'(bus.left_data_o), e_ld);
      check({t, " left_prec"},  64'(bus.left_precision_o), e_lp);
      check({t, " top_valid"},  64'(bus.top_data_valid_o), e_tv);
      check({t, " top_cnt"},    64'(bus.top_data_cnt_o), e_tc);
      check({t, " top_data"},   64'(bus.top_data_o), e_td);
      check({t, " storec"},     64'(bus.top_storec_valid_o), 64'd0);
      tick();
    end
  endtask

  initial begin
    bus.cmd_valid_i     = 1'b0;
    bus.cmd_k_i         = '0;
    bus.cmd_precision_i = '0;
    bus.a_valid_i       = 1'b0;
    bus.a_data_i        = '0;
    bus.b_valid_i       = 1'b0;
    bus.b_data_i        = '0;

    // Reset: everything low, including cmd_ready while reset is held.
    #2;
    check_quiet("reset", 1'b0);
    check("reset left_prec", 64'(bus.left_precision_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

    // Nominal K=3: fires 1..3, drain 4..11, done 12, ready again at 13.
    run_op(3, 1, 0, 0, 1'b0, 0, 0);
    // Two-cycle stall on B after the first fire: fires 1,4,5, done 14.
    run_op(3, 1, 2, 1, 1'b0, 0, 0);
    // K=0: straight to DONE with no pulls and no edge valids.
    run_op(0, 3, 0, 1, 1'b0, 0, 0);

    // Reset after the second fire of a K=5 command.
    bus.cmd_valid_i     = 1'b1;
    bus.cmd_k_i         = 8'd5;
    bus.cmd_precision_i = 2'd2;
    bus.a_valid_i       = 1'b1;
    bus.b_valid_i       = 1'b1;
    #1;
    check("k5 accept cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    tick();
    check("k5 c3 left_valid", 64'(bus.left_data_valid_o), 64'h3);
    check("k5 c3 top_valid",  64'(bus.top_data_valid_o), 64'h3);
    rst_n = 1'b0;
    #1;
    check_quiet("midop reset", 1'b0);
    check("midop reset left_prec", 64'(bus.left_precision_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_quiet($sformatf("after reset c%0d", c), 1'b1);
    end

    // Back-to-back with cmd_valid held: second command accepted the cycle after done.
    run_op(3, 1, 0, 0, 1'b1, 3, 2);
    run_op(3, 2, 0, 1, 1'b0, 0, 0);
    bus.cmd_valid_i = 1'b0;
    #1;
    check("final cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("final left_prec", 64'(bus.left_precision_o), 64'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
